// File: rtl/mac_v4.sv
// mac_v4: signed multiply-accumulate of K streamed (feature, weight) pairs plus bias,
// result presented on a valid/ready port and held until accepted.
module mac_v4 #(
  parameter int INPUT_BIT_RESOLUTION  = 8,
  parameter int OUTPUT_BIT_RESOLUTION = 32,
  parameter int KERNEL_SIZE_W         = 3,
  parameter int KERNEL_SIZE_H         = 3
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             mac_fin_and_kernel_valid_i,
  input  logic [INPUT_BIT_RESOLUTION-1:0]  mac_fin_data_i,
  input  logic [INPUT_BIT_RESOLUTION-1:0]  mac_kernel_data_i,
  input  logic [OUTPUT_BIT_RESOLUTION-1:0] mac_kernel_bias_i,
  output logic                             mac_valid_o,
  output logic [OUTPUT_BIT_RESOLUTION-1:0] mac_data_o,
  input  logic                             mac_ready_i
);
  localparam int IW = INPUT_BIT_RESOLUTION;
  localparam int OW = OUTPUT_BIT_RESOLUTION;
  localparam int K  = KERNEL_SIZE_W * KERNEL_SIZE_H;
  localparam int CW = $clog2(K) + 1;

  typedef enum logic {ACCUM, DONE} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [OW-1:0]   acc, acc_nx, data, data_nx, prod_ext, sum;
  logic signed [2*IW-1:0] prod;
  logic            beat, last;

  assign prod     = (2*IW)'($signed(mac_fin_data_i)) * (2*IW)'($signed(mac_kernel_data_i));
  assign prod_ext = OW'(prod);
  assign beat     = state == ACCUM && mac_fin_and_kernel_valid_i;
  assign last     = cnt == CW'(K - 1);
  // bias enters only on the first beat, replacing the stale accumulator
  assign sum      = (cnt == '0 ? mac_kernel_bias_i : acc) + prod_ext;

  always_comb begin
    state_nx = beat && last ? DONE : (state == DONE && mac_ready_i) ? ACCUM : state;
    cnt_nx   = beat ? (last ? '0 : cnt + CW'(1)) : cnt;
    acc_nx   = beat ? sum : acc;
    data_nx  = beat && last ? sum : data;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= ACCUM;
      cnt   <= '0;
      acc   <= '0;
      data  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      acc   <= acc_nx;
      data  <= data_nx;
    end
  end

  assign mac_valid_o = state == DONE;
  assign mac_data_o  = data;
endmodule

// File: tb/tb_mac_v4.sv
// tb_mac_v4: randomized and directed checks of mac_v4 against a plain-arithmetic
// sum-of-products model; a second K=1, 16-bit instance covers wrap-around.
module tb_mac_v4;
  logic clk = 0, rst_n = 0;
  always #50 clk = ~clk;

  logic v, rdy, vo;
  logic [7:0] a, b;
  logic [31:0] bias, dout;
  logic wv, wvo;
  logic [7:0] wa, wb;
  logic [15:0] wbias, wdo;

  int n_cmp = 0, n_err = 0;
  int fa[9], fb[9];

  mac_v4 dut (
    .clk_i(clk), .rst_ni(rst_n), .mac_fin_and_kernel_valid_i(v),
    .mac_fin_data_i(a), .mac_kernel_data_i(b), .mac_kernel_bias_i(bias),
    .mac_valid_o(vo), .mac_data_o(dout), .mac_ready_i(rdy)
  );

  mac_v4 #(.OUTPUT_BIT_RESOLUTION(16), .KERNEL_SIZE_W(1), .KERNEL_SIZE_H(1)) dut_w (
    .clk_i(clk), .rst_ni(rst_n), .mac_fin_and_kernel_valid_i(wv),
    .mac_fin_data_i(wa), .mac_kernel_data_i(wb), .mac_kernel_bias_i(wbias),
    .mac_valid_o(wvo), .mac_data_o(wdo), .mac_ready_i(1'b1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] expect_sum(input logic [31:0] bs);
    int s = int'(bs);
    for (int i = 0; i < 9; i++) s += fa[i] * fb[i];
    return s;
  endfunction

  task automatic run_kernel(input string tag, input logic [31:0] bs, input int gap_pct);
    for (int i = 0; i < 9; i++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        step();
        chk({tag, "_busy"}, vo, 0);
        v = 0;
        a = 8'($urandom);
        b = 8'($urandom);
        bias = $urandom;
      end
      step();
      chk({tag, "_busy"}, vo, 0);
      v = 1;
      a = 8'(fa[i]);
      b = 8'(fb[i]);
      bias = i == 0 ? bs : $urandom;
    end
    step();
    v = 0;
    chk({tag, "_valid"}, vo, 1);
    chk({tag, "_data"}, dout, expect_sum(bs));
  endtask

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] e;
    logic [15:0] we, wbs;
    int x, y;
    v = 0; rdy = 1; a = 0; b = 0; bias = 0;
    wv = 0; wa = 0; wb = 0; wbias = 0;
    repeat (10) begin
      step();
      chk("rst_valid", vo, 0);
      chk("rst_data", dout, 0);
    end
    rst_n = 1;

    fa = '{1, 2, -3, 4, 5, 6, 7, 8, 9};
    fb = '{1, 2, 3, 4, 5, -6, 7, 8, 9};
    run_kernel("basic", 100, 0);
    chk("basic_295", dout, 295);
    step();
    chk("basic_pulse", vo, 0);
    chk("basic_hold", dout, 295);

    rdy = 0;
    run_kernel("bp", 100, 0);
    repeat (5) begin
      step();
      chk("bp_valid", vo, 1);
      chk("bp_data", dout, 295);
      v = 1; a = 8'($urandom); b = 8'($urandom); bias = $urandom;
    end
    step();
    chk("bp_valid_last", vo, 1);
    rdy = 1; v = 1; a = 50; b = 50; bias = 1000;
    step();
    v = 0;
    chk("bp_release", vo, 0);
    chk("bp_release_data", dout, 295);
    fa = '{default: 1};
    fb = '{default: 1};
    run_kernel("ones", 0, 0);
    chk("ones_9", dout, 9);
    step();
    chk("ones_pulse", vo, 0);

    fa = '{default: -128};
    fb = '{default: -128};
    run_kernel("gap", 32'hFFFF_FFFF, 40);
    chk("gap_147455", dout, 147455);
    step();
    chk("gap_pulse", vo, 0);

    for (int i = 0; i < 4; i++) begin
      step();
      v = 1; a = 8'($urandom); b = 8'($urandom); bias = $urandom;
    end
    step();
    v = 0;
    #10 rst_n = 0;
    #1;
    chk("rstmid_valid", vo, 0);
    chk("rstmid_data", dout, 0);
    step();
    step();
    rst_n = 1;
    fa = '{default: 2};
    fb = '{default: 3};
    run_kernel("rstmid", 0, 0);
    chk("rstmid_54", dout, 54);
    step();
    chk("rstmid_pulse", vo, 0);

    repeat (20) begin
      for (int i = 0; i < 9; i++) begin
        fa[i] = int'($urandom_range(255)) - 128;
        fb[i] = int'($urandom_range(255)) - 128;
      end
      e = $urandom;
      rdy = 1'($urandom_range(1));
      run_kernel("rand", e, int'($urandom_range(50)));
      if (!rdy) begin
        repeat ($urandom_range(1, 4)) begin
          step();
          chk("rand_hold_valid", vo, 1);
          chk("rand_hold_data", dout, expect_sum(e));
        end
        rdy = 1;
      end
      step();
      chk("rand_release", vo, 0);
    end

    step();
    wv = 1; wa = 1; wb = 1; wbias = 16'h7FFF;
    step();
    wv = 0;
    chk("wrap_valid", wvo, 1);
    chk("wrap_data", wdo, 16'h8000);
    step();
    chk("wrap_pulse", wvo, 0);
    repeat (10) begin
      x = int'($urandom_range(255)) - 128;
      y = int'($urandom_range(255)) - 128;
      wbs = 16'($urandom);
      we = 16'(int'(wbs) + x * y);
      wv = 1; wa = 8'(x); wb = 8'(y); wbias = wbs;
      step();
      wv = 0;
      chk("k1_valid", wvo, 1);
      chk("k1_data", wdo, we);
      step();
      chk("k1_pulse", wvo, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
